// File: rtl/asrv32_writeback_pipe.sv
// asrv32 writeback stage.
// Registers the rd writeback (ALU / load / CSR source), resolves PC redirects
// (trap, MRET, JAL, JALR, taken branch), holds a flush window after every
// redirect, stalls while load data is outstanding and counts retired
// instructions.

package asrv32_header_pkg;
  // One-hot opcode bit positions shared with the decode stage.
  localparam int OPCODE_WIDTH = 11;
  localparam int RTYPE  = 0;
  localparam int ITYPE  = 1;
  localparam int LOAD   = 2;
  localparam int STORE  = 3;
  localparam int BRANCH = 4;
  localparam int JAL    = 5;
  localparam int JALR   = 6;
  localparam int LUI    = 7;
  localparam int AUIPC  = 8;
  localparam int SYSTEM = 9;
  localparam int FENCE  = 10;
endpackage

module asrv32_writeback_pipe
  import asrv32_header_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] PC_RESET     = '0,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              CNT_W        = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ce,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [XLEN-1:0]         i_imm,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic                    i_branch_taken,
  input  logic [XLEN-1:0]         i_rd_data,
  input  logic [XLEN-1:0]         i_load_data,
  input  logic                    i_load_ack,
  input  logic [XLEN-1:0]         i_csr_data,
  input  logic                    i_go_to_trap,
  input  logic                    i_return_from_trap,
  input  logic [XLEN-1:0]         i_trap_address,
  input  logic [XLEN-1:0]         i_return_address,
  input  logic                    i_wr_rd_en,
  input  logic [4:0]              i_rd_addr,
  output logic                    o_wr_rd_en,
  output logic [4:0]              o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
  output logic [XLEN-1:0]         o_next_pc,
  output logic                    o_change_pc,
  output logic                    o_flush,
  output logic                    o_stall,
  output logic [CNT_W-1:0]        o_instret
);

  // Flush counter holds FLUSH_CYCLES-1 down to 0; keep at least one bit.
  localparam int CNT_FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e            state;
  logic [CNT_FW-1:0] flush_cnt;

  // Opcode decode.
  logic is_load, is_branch, is_jal, is_jalr, is_system;
  assign is_load   = i_opcode[LOAD];
  assign is_branch = i_opcode[BRANCH];
  assign is_jal    = i_opcode[JAL];
  assign is_jalr   = i_opcode[JALR];
  assign is_system = i_opcode[SYSTEM];

  // Opcode classes that need no special handling in this stage.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^{i_opcode[RTYPE], i_opcode[ITYPE], i_opcode[STORE],
                                i_opcode[LUI], i_opcode[AUIPC], i_opcode[FENCE]};

  // A trapping load never waits for its data: the trap takes over the stage.
  logic load_pending;
  assign load_pending = is_load && !i_load_ack && !i_go_to_trap;

  logic run_valid;
  assign run_valid = (state == ST_RUN) && i_ce;

  logic accept;
  assign accept = run_valid && !load_pending;

  // Gated with reset so the stall cannot leak out while the stage is held in reset.
  assign o_stall = i_rst_n && run_valid && load_pending;

  logic wr_en_next;
  assign wr_en_next = i_wr_rd_en && (i_rd_addr != 5'd0) && !i_go_to_trap;

  logic retire;
  assign retire = accept && !i_go_to_trap;

  // Writeback value source select.
  logic [XLEN-1:0] rd_value;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_value = i_rd_data;
    if (is_load) begin
      rd_value = i_load_data;
    end else if (is_system && (i_funct3 != 3'd0)) begin
      rd_value = i_csr_data;
    end
  end

  // Redirect target resolution in priority order; adds wrap modulo 2^XLEN.
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;
  logic            redirect;
  logic [XLEN-1:0] target;

  assign pc_plus_imm  = i_pc + i_imm;
  assign rs1_plus_imm = i_rs1_data + i_imm;

  always_comb begin
    redirect = 1'b1;
    target   = i_trap_address;
    if (i_go_to_trap) begin
      target = i_trap_address;
    end else if (i_return_from_trap) begin
      target = i_return_address;
    end else if (is_jal) begin
      target = pc_plus_imm;
    end else if (is_jalr) begin
      target = {rs1_plus_imm[XLEN-1:1], 1'b0};
    end else if (is_branch && i_branch_taken) begin
      target = pc_plus_imm;
    end else begin
      redirect = 1'b0;
    end
  end

  // Stage registers and RUN/FLUSH control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_rd_en  <= 1'b0;
      o_rd_addr   <= 5'd0;
      o_rd_data   <= '0;
      o_next_pc   <= PC_RESET;
      o_change_pc <= 1'b0;
      o_flush     <= 1'b0;
      o_instret   <= '0;
      state       <= ST_RUN;
      flush_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the defaults below are overridden further down.
      o_wr_rd_en  <= 1'b0;
      o_change_pc <= 1'b0;

      if (state == ST_RUN) begin
        o_flush <= 1'b0;
        if (accept) begin
          o_wr_rd_en <= wr_en_next;
          o_rd_addr  <= i_rd_addr;
          o_rd_data  <= rd_value;
          if (retire) begin
            o_instret <= o_instret + CNT_W'(1);
          end
          if (redirect) begin
            o_change_pc <= 1'b1;
            o_next_pc   <= target;
            o_flush     <= 1'b1;
            // A one-cycle window is covered by o_flush alone; stay in RUN.
            if (FLUSH_CYCLES > 1) begin
              state     <= ST_FLUSH;
              flush_cnt <= CNT_FW'(FLUSH_CYCLES - 1);
            end
          end
        end
      end else begin
        // Flush window: incoming instructions are dropped without effect.
        if (flush_cnt == '0) begin
          state   <= ST_RUN;
          o_flush <= 1'b0;
        end else begin
          flush_cnt <= flush_cnt - CNT_FW'(1);
          o_flush   <= 1'b1;
        end
      end
    end
  end

endmodule
